// File: rtl/jt51_eg_mon.sv
// rtl/jt51_eg_mon.sv - EG attenuation stream demux into per-slot live/peak arrays with req/ack readback
module jt51_eg_mon #(
  parameter int ZERO_SLOT = 0,
  parameter int SLOTS     = 32
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       zero,
  input  logic [9:0] eg_xi,
  input  logic       freeze,
  input  logic       peak_clr,
  input  logic       rd_req,
  input  logic       rd_sel,
  input  logic [4:0] rd_slot,
  output logic       rd_ack,
  output logic [9:0] rd_data,
  output logic       synced,
  output logic       busy
);

  localparam logic [4:0] ZS = 5'(ZERO_SLOT);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ACK} rd_state_t;

  logic [9:0] live [SLOTS];
  logic [9:0] peak [SLOTS];

  logic [4:0] slot_cnt, cur, clr_cnt;
  logic       freeze_act, clr_pend, clr_run;
  logic       frame_start, wr_en, freeze_eff, clr_eff, live_we, peak_we;

  rd_state_t  state, state_nx;
  logic       accept;
  logic       sel_q;
  logic [4:0] slot_q;
  logic [9:0] entry;

  // The frame-start cycle already carries slot ZERO_SLOT of the new frame, so it
  // must see the new freeze/clear decision for a snapshot to hold one whole frame.
  always_comb begin
    frame_start = cen & zero;
    cur         = zero ? ZS : slot_cnt;
    wr_en       = cen & synced;
    freeze_eff  = frame_start ? freeze : freeze_act;
    clr_eff     = clr_run | (frame_start & clr_pend);
    live_we     = wr_en & ~freeze_eff;
    peak_we     = wr_en & (clr_eff | (eg_xi < peak[cur]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= 5'd0;
      synced     <= 1'b0;
      freeze_act <= 1'b0;
      clr_pend   <= 1'b0;
      clr_run    <= 1'b0;
      clr_cnt    <= 5'd0;
      for (int i = 0; i < SLOTS; i++) begin
        live[i] <= 10'h3FF;
        peak[i] <= 10'h3FF;
      end
    end else begin
      if (cen) slot_cnt <= cur + 5'd1;
      if (frame_start) begin
        synced     <= 1'b1;
        freeze_act <= freeze;
      end
      if (live_we) live[cur] <= eg_xi;
      if (peak_we) peak[cur] <= eg_xi;
      // clr_run covers the frame-start cycle (via clr_eff) plus 31 further cen cycles
      if (frame_start && clr_pend) begin
        clr_run <= 1'b1;
        clr_cnt <= 5'd1;
      end else if (cen && clr_run) begin
        clr_cnt <= clr_cnt + 5'd1;
        if (clr_cnt == 5'd31) clr_run <= 1'b0;
      end
      if (frame_start && clr_pend) clr_pend <= 1'b0;
      if (peak_clr) clr_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      S_IDLE:  if (rd_req && !busy) begin
                 accept   = 1'b1;
                 state_nx = S_FETCH;
               end
      S_FETCH: state_nx = S_ACK;
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      rd_ack  <= 1'b0;
      rd_data <= 10'h3FF;
      entry   <= 10'h3FF;
      sel_q   <= 1'b0;
      slot_q  <= 5'd0;
    end else begin
      rd_ack <= 1'b0;
      if (accept) begin
        busy   <= 1'b1;
        sel_q  <= rd_sel;
        slot_q <= rd_slot;
      end else if (state == S_IDLE) begin
        busy <= 1'b0;
      end
      if (state == S_FETCH) entry <= sel_q ? peak[slot_q] : live[slot_q];
      if (state == S_ACK) begin
        rd_data <= entry;
        rd_ack  <= 1'b1;
      end
    end
  end

endmodule
